// File: rtl/sensor_acquisition.sv
// sensor_acquisition: four-channel tick-sampled moving-average front end; ports clk, rst, sample_en, raw1..4 in, sensor1..4, valid, new_sample out; optional ZERO_PROPAGATE_EN forces zero output while a zero sample sits in the window
module sensor_acquisition #(
  parameter int AVG_LOG2   = 2,
  parameter int SAMPLE_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic [7:0] raw1,
  input  logic [7:0] raw2,
  input  logic [7:0] raw3,
  input  logic [7:0] raw4,
  output logic [7:0] sensor1,
  output logic [7:0] sensor2,
  output logic [7:0] sensor3,
  output logic [7:0] sensor4,
  output logic       valid,
  output logic       new_sample
);
  localparam int DEPTH = 2 ** AVG_LOG2;
  localparam int SW = 8 + AVG_LOG2;
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int FW = AVG_LOG2 + 1;
  logic [CW-1:0] cnt;
  logic [FW-1:0] fill;
  logic [7:0] raw_a [4];
  logic [7:0] sens [4];
  logic [7:0] out_n [4];
  logic [7:0] win [4][DEPTH];
  logic [SW-1:0] sum [4];
  logic [SW-1:0] sum_n [4];
  logic tick, full, valid_n;
  assign raw_a = '{raw1, raw2, raw3, raw4};
  assign {sensor1, sensor2, sensor3, sensor4} = {sens[0], sens[1], sens[2], sens[3]};
  assign tick = sample_en && cnt == CW'(SAMPLE_DIV - 1);
  assign full = fill == FW'(DEPTH);
  assign valid_n = valid || (tick && fill == FW'(DEPTH - 1));
`ifdef ZERO_PROPAGATE_EN
  logic [FW-1:0] zc [4];
  logic [FW-1:0] zc_n [4];
  // Reset-cleared window slots are not samples, so only a real oldest zero leaves the count
  always_comb
    for (int i = 0; i < 4; i++) begin
      sum_n[i] = sum[i] + SW'(raw_a[i]) - SW'(win[i][DEPTH-1]);
      zc_n[i] = zc[i] + FW'(raw_a[i] == 8'd0) - FW'(full && win[i][DEPTH-1] == 8'd0);
      out_n[i] = zc_n[i] != '0 ? 8'd0 : 8'(sum_n[i] >> AVG_LOG2);
    end
`else
  always_comb
    for (int i = 0; i < 4; i++) begin
      sum_n[i] = sum[i] + SW'(raw_a[i]) - SW'(win[i][DEPTH-1]);
      out_n[i] = 8'(sum_n[i] >> AVG_LOG2);
    end
`endif
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      fill <= '0;
      valid <= 1'b0;
      new_sample <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sum[i] <= '0;
        sens[i] <= '0;
`ifdef ZERO_PROPAGATE_EN
        zc[i] <= '0;
`endif
        for (int k = 0; k < DEPTH; k++) win[i][k] <= '0;
      end
    end else begin
      if (sample_en) cnt <= tick ? '0 : cnt + CW'(1);
      valid <= valid_n;
      new_sample <= tick && valid_n;
      if (tick) begin
        if (!full) fill <= fill + FW'(1);
        for (int i = 0; i < 4; i++) begin
          sum[i] <= sum_n[i];
          sens[i] <= out_n[i];
`ifdef ZERO_PROPAGATE_EN
          zc[i] <= zc_n[i];
`endif
          win[i][0] <= raw_a[i];
          for (int k = 1; k < DEPTH; k++) win[i][k] <= win[i][k-1];
        end
      end
    end
endmodule

// File: tb/tb_sensor_acquisition.sv
// tb_sensor_acquisition: randomized and directed stimulus checked against a queue-based averaging model
module tb_sensor_acquisition;
  logic clk = 1'b0;
  logic rst, sample_en;
  logic [7:0] raw1, raw2, raw3, raw4;
  logic [7:0] sensor1, sensor2, sensor3, sensor4;
  logic valid, new_sample;
  int checks = 0;
  int errors = 0;
  int en_cnt, n_samples;
  int hist [4][$];
  int exp_s [4];
  bit exp_valid, exp_ns, prev_ns;
  always #5 clk = ~clk;
  sensor_acquisition #(.AVG_LOG2(2), .SAMPLE_DIV(4)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en),
    .raw1(raw1), .raw2(raw2), .raw3(raw3), .raw4(raw4),
    .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3), .sensor4(sensor4),
    .valid(valid), .new_sample(new_sample)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model(input bit r, input bit en, input int a, input int b, input int c, input int d);
    int raws [4];
    bit tick;
    raws = '{a, b, c, d};
    if (r) begin
      en_cnt = 0;
      n_samples = 0;
      foreach (hist[i]) hist[i].delete();
      exp_s = '{0, 0, 0, 0};
      exp_valid = 0;
      exp_ns = 0;
      return;
    end
    tick = en && en_cnt == 3;
    if (en) en_cnt = (en_cnt + 1) % 4;
    exp_ns = 0;
    if (!tick) return;
    n_samples++;
    if (n_samples >= 4) exp_valid = 1;
    exp_ns = exp_valid;
    for (int i = 0; i < 4; i++) begin
      int s;
      bit z;
      hist[i].push_front(raws[i]);
      if (hist[i].size() > 4) void'(hist[i].pop_back());
      s = 0;
      z = 0;
      foreach (hist[i][k]) begin
        s += hist[i][k];
        if (hist[i][k] == 0) z = 1;
      end
      exp_s[i] = s / 4;
`ifdef ZERO_PROPAGATE_EN
      if (z) exp_s[i] = 0;
`endif
    end
  endtask
  task automatic cyc(input bit r, input bit en, input int a, input int b, input int c, input int d);
    rst = r;
    sample_en = en;
    raw1 = 8'(a);
    raw2 = 8'(b);
    raw3 = 8'(c);
    raw4 = 8'(d);
    @(posedge clk);
    model(r, en, a, b, c, d);
    #1;
    chk("sensor1", sensor1, exp_s[0]);
    chk("sensor2", sensor2, exp_s[1]);
    chk("sensor3", sensor3, exp_s[2]);
    chk("sensor4", sensor4, exp_s[3]);
    chk("valid", valid, exp_valid);
    chk("new_sample", new_sample, exp_ns);
    chk("ns_back_to_back", new_sample && prev_ns, 0);
    prev_ns = new_sample;
  endtask
  initial begin
    prev_ns = 0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    for (int n = 0; n < 24; n++) cyc(0, 1, 100, 100, 100, 100);
    for (int n = 0; n < 20; n++) cyc(0, 1, 200, 100, 100, 100);
    for (int n = 0; n < 2; n++) cyc(0, 1, 200, 100, 100, 100);
    for (int n = 0; n < 10; n++) cyc(0, 0, $urandom_range(255), 100, 100, 100);
    for (int n = 0; n < 12; n++) cyc(0, 1, 200, 100, 100, 100);
    for (int n = 0; n < 4; n++) cyc(0, 1, 200, 100, 1, 100);
    for (int n = 0; n < 12; n++) cyc(0, 1, 200, 100, 2, 100);
    for (int n = 0; n < 20; n++) cyc(0, 1, 255, 255, 255, 255);
    for (int n = 0; n < 16; n++) cyc(0, 1, 100, 100, 100, 100);
    for (int n = 0; n < 4; n++) cyc(0, 1, 100, 0, 100, 100);
    for (int n = 0; n < 24; n++) cyc(0, 1, 100, 100, 100, 100);
    for (int n = 0; n < 8; n++) cyc(0, 1, 50, 60, 70, 80);
    cyc(1, 1, 50, 60, 70, 80);
    for (int n = 0; n < 20; n++) cyc(0, 1, 90, 90, 90, 90);
    for (int n = 0; n < 1500; n++) begin
      int a, b;
      a = $urandom_range(7) == 0 ? 0 : $urandom_range(255);
      b = $urandom_range(3) == 0 ? 255 : $urandom_range(255);
      cyc($urandom_range(150) == 0, $urandom_range(5) != 0, a, b, $urandom_range(255), $urandom_range(3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
